// File: rtl/joypad_pkg.sv
// Shared constants and types for the joypad tick generator.
// Button indices follow the SNES serial order (bit 15 = B).
package joypad_pkg;

    localparam int BTN_B      = 15;
    localparam int BTN_Y      = 14;
    localparam int BTN_SELECT = 13;
    localparam int BTN_START  = 12;
    localparam int BTN_UP     = 11;
    localparam int BTN_DOWN   = 10;
    localparam int BTN_LEFT   = 9;
    localparam int BTN_RIGHT  = 8;
    localparam int BTN_A      = 7;
    localparam int BTN_X      = 6;
    localparam int BTN_L      = 5;
    localparam int BTN_R      = 4;

    localparam int DEBOUNCE_CNT_W = 4;
    localparam int HOLD_CNT_W     = 8;

    typedef enum logic [1:0] {
        CH_IDLE             = 2'd0,
        CH_DEBOUNCE_PRESS   = 2'd1,
        CH_HELD             = 2'd2,
        CH_DEBOUNCE_RELEASE = 2'd3
    } chan_state_e;

    // A channel is in a debounce state whenever a differing run is pending.
    function automatic chan_state_e chan_state(
        input logic stable,
        input logic pending
    );
        chan_state_e s;
        unique case (1'b1)
            (!stable && !pending): s = CH_IDLE;
            (!stable &&  pending): s = CH_DEBOUNCE_PRESS;
            ( stable && !pending): s = CH_HELD;
            default:               s = CH_DEBOUNCE_RELEASE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/joypad_button_channel.sv
// One button: debounce FSM, optional hold-repeat counter, tick register.
// Auto-repeat is built only when JOYPAD_AUTOREPEAT_EN is defined.
module joypad_button_channel #(
    parameter int DEBOUNCE_FRAMES     = 2,
    parameter int REPEAT_DELAY_FRAMES = 20,
    parameter int REPEAT_RATE_FRAMES  = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic sample,
    input  logic valid,
    output logic stable,
    output logic tick
);
    import joypad_pkg::*;

    localparam logic [DEBOUNCE_CNT_W-1:0] DEB_MAX =
        DEBOUNCE_CNT_W'(DEBOUNCE_FRAMES);

    chan_state_e               state_q;
    chan_state_e               state_d;
    logic [DEBOUNCE_CNT_W-1:0] deb_q;
    logic [DEBOUNCE_CNT_W-1:0] deb_d;
    logic [DEBOUNCE_CNT_W-1:0] deb_inc;
    logic                      stable_now;
    logic                      stable_d;
    logic                      differ;
    logic                      flip;
    logic                      press;
    logic                      rpt;
    logic                      tick_q;

    always_comb begin
        stable_now = (state_q == CH_HELD) ||
                     (state_q == CH_DEBOUNCE_RELEASE);
        deb_inc    = deb_q + 1'b1;
        differ     = sample ^ stable_now;
        flip       = valid && differ && (deb_inc == DEB_MAX);
        press      = flip && !stable_now;
        stable_d   = stable_now ^ flip;
        deb_d      = deb_q;
        if (valid) begin
            // A matching sample cancels any partial debounce run.
            deb_d = (!differ || flip) ? '0 : deb_inc;
        end
        state_d = chan_state(stable_d, deb_d != '0);
    end

`ifdef JOYPAD_AUTOREPEAT_EN
    localparam logic [HOLD_CNT_W-1:0] RPT_DELAY =
        HOLD_CNT_W'(REPEAT_DELAY_FRAMES);
    localparam logic [HOLD_CNT_W-1:0] RPT_RELOAD =
        HOLD_CNT_W'(REPEAT_DELAY_FRAMES - REPEAT_RATE_FRAMES);

    logic [HOLD_CNT_W-1:0] hold_q;
    logic [HOLD_CNT_W-1:0] hold_d;
    logic [HOLD_CNT_W-1:0] hold_inc;

    always_comb begin
        hold_inc = hold_q + 1'b1;
        hold_d   = hold_q;
        rpt      = 1'b0;
        if (valid) begin
            if (!stable_d || press) begin
                hold_d = '0;
            end else if (hold_inc == RPT_DELAY) begin
                rpt    = 1'b1;
                hold_d = RPT_RELOAD;
            end else begin
                hold_d = hold_inc;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{8'(REPEAT_DELAY_FRAMES),
                                 8'(REPEAT_RATE_FRAMES)};
    assign rpt = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CH_IDLE;
            deb_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            tick_q  <= press | rpt;
        end
    end

    assign stable = (state_q == CH_HELD) ||
                    (state_q == CH_DEBOUNCE_RELEASE);
    assign tick   = tick_q;

endmodule

// File: rtl/joypad_tick_generator.sv
// Debounced joypad levels and press/repeat tick pulses per button.
// Define JOYPAD_AUTOREPEAT_EN to build hold-to-repeat ticks.
module joypad_tick_generator #(
    parameter int NUM_BUTTONS         = 16,
    parameter int DEBOUNCE_FRAMES     = 2,
    parameter int REPEAT_DELAY_FRAMES = 20,
    parameter int REPEAT_RATE_FRAMES  = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] inPadState,
    input  logic                   inPadValid,
    output logic [NUM_BUTTONS-1:0] outPadStable,
    output logic [NUM_BUTTONS-1:0] outPadTick,
    output logic                   outUp_tick,
    output logic                   outDown_tick
);
    import joypad_pkg::*;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        joypad_button_channel #(
            .DEBOUNCE_FRAMES     (DEBOUNCE_FRAMES),
            .REPEAT_DELAY_FRAMES (REPEAT_DELAY_FRAMES),
            .REPEAT_RATE_FRAMES  (REPEAT_RATE_FRAMES)
        ) u_chan (
            .clock  (clock),
            .reset  (reset),
            .sample (inPadState[i]),
            .valid  (inPadValid),
            .stable (outPadStable[i]),
            .tick   (outPadTick[i])
        );
    end

    assign outUp_tick   = outPadTick[BTN_UP];
    assign outDown_tick = outPadTick[BTN_DOWN];

endmodule

// File: tb/tb_joypad_tick_generator.sv
// Scoreboard bench: random and directed samples vs. a run-length model.
// Honours JOYPAD_AUTOREPEAT_EN the same way as the design.
module tb_joypad_tick_generator;

    localparam int NB    = 16;
    localparam int DEB   = 2;
    localparam int DELAY = 20;
    localparam int RATE  = 4;
    localparam int UP    = 11;
    localparam int DOWN  = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] inPadState = '0;
    logic          inPadValid = 1'b0;
    logic [NB-1:0] outPadStable;
    logic [NB-1:0] outPadTick;
    logic          outUp_tick;
    logic          outDown_tick;

    always #5 clock = ~clock;

    joypad_tick_generator #(
        .NUM_BUTTONS         (NB),
        .DEBOUNCE_FRAMES     (DEB),
        .REPEAT_DELAY_FRAMES (DELAY),
        .REPEAT_RATE_FRAMES  (RATE)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .inPadState   (inPadState),
        .inPadValid   (inPadValid),
        .outPadStable (outPadStable),
        .outPadTick   (outPadTick),
        .outUp_tick   (outUp_tick),
        .outDown_tick (outDown_tick)
    );

    typedef struct {
        logic [NB-1:0] st;
        logic [NB-1:0] tk;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   dn_ticks = 0;

`ifdef JOYPAD_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    // Model: stable level, length of current differing run,
    // samples held since the press.
    bit m_st[NB];
    int m_run[NB];
    int m_held[NB];

    task automatic check(input string name, input logic [NB-1:0] act,
                         input logic [NB-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, req, $time);
        end
    endtask

    task automatic step(input bit rst, input bit vld,
                        input logic [NB-1:0] s);
        exp_t e;
        @(negedge clock);
        reset      = rst;
        inPadValid = vld;
        inPadState = s;
        e.tk = '0;
        for (int b = 0; b < NB; b++) begin
            if (rst) begin
                m_st[b]   = 1'b0;
                m_run[b]  = 0;
                m_held[b] = 0;
            end else if (vld) begin
                bit was = m_st[b];
                bit flipped = 1'b0;
                if (s[b] == m_st[b]) begin
                    m_run[b] = 0;
                end else begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        m_st[b]   = !m_st[b];
                        m_run[b]  = 0;
                        m_held[b] = 0;
                        flipped   = 1'b1;
                        if (m_st[b]) e.tk[b] = 1'b1;
                    end
                end
                if (was && !flipped) begin
                    m_held[b]++;
                    if (AR && m_held[b] >= DELAY &&
                        (m_held[b] - DELAY) % RATE == 0)
                        e.tk[b] = 1'b1;
                end
            end
            e.st[b] = m_st[b];
        end
        q.push_back(e);
    endtask

    task automatic frame(input logic [NB-1:0] s);
        step(1'b0, 1'b1, s);
        repeat (9) step(1'b0, 1'b0, s);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (outDown_tick === 1'b1) dn_ticks++;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("stable", outPadStable, e.st);
                check("tick", outPadTick, e.tk);
                check("up_tap", NB'(outUp_tick), NB'(e.tk[UP]));
                check("down_tap", NB'(outDown_tick), NB'(e.tk[DOWN]));
            end
        end
    end

    initial begin : stim
        logic [NB-1:0] up_m;
        logic [NB-1:0] dn_m;
        logic [NB-1:0] word;
        int base;
        int want;
        up_m = '0; up_m[UP] = 1'b1;
        dn_m = '0; dn_m[DOWN] = 1'b1;

        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, '1);
        step(1'b0, 1'b0, '0);

        repeat (2) frame(up_m);
        repeat (2) frame('0);

        frame(up_m); frame('0); frame(up_m);
        repeat (2) frame('0);

        repeat (2) step(1'b0, 1'b0, '0);
        base = dn_ticks;
        repeat (40) frame(dn_m);
        repeat (2) frame('0);
        repeat (2) step(1'b0, 1'b0, '0);
        want = AR ? 6 : 1;
        total++;
        if (dn_ticks - base != want) begin
            bad++;
            $display("FAIL down_hold_count: got %0d expected %0d",
                     dn_ticks - base, want);
        end

        repeat (2) frame(up_m | dn_m);
        repeat (2) frame('0);

        repeat (20) frame(up_m);
        step(1'b1, 1'b1, up_m);
        repeat (9) step(1'b0, 1'b0, up_m);
        repeat (3) frame(up_m);
        repeat (2) frame('0);

        word = '0;
        for (int i = 0; i < 3000; i++) begin
            word ^= NB'($urandom & $urandom & $urandom &
                        $urandom & $urandom & $urandom);
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 1) == 1, word);
        end

        repeat (3) step(1'b0, 1'b0, '0);
        @(posedge clock);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
